acfa_metadata_regs: RTL and testbench
=====================================

Name: acfa_metadata_regs

Overview:
- Parametrised successor of the ACFA metadata peripheral on the openMSP430 peripheral bus.
- Holds the attestation challenge, NUM_ER executable-region bound pairs, and the control-flow log pointer with high-water and overflow tracking.
- Adds a two-step lock state machine that freezes challenge and ER registers during attestation.
- Drives region bounds and status flags to the ACFA monitor.

Parameters:
- BASE_ADDR, 15'h0180, byte base address; must be even.
- CHAL_WORDS, 16, challenge size in 16-bit words (1..32).
- NUM_ER, 2, number of ER_min/ER_max pairs (1..8).
- LOG_LIMIT, 16'h0400, log pointer value at or above which overflow is flagged.
- UNLOCK_KEY, 16'hA5A5, first lock-sequence word.
- LOCK_KEY, 16'h5A5A, second lock-sequence word.

Ports:
- mclk  in  1  main clock
- puc_rst  in  1  reset
- per_addr  in  14  peripheral word address
- per_din  in  16  write data
- per_en  in  1  peripheral enable
- per_we  in  2  byte write enables; [0] low byte, [1] high byte
- cflow_logs_ptr_din  in  16  current log pointer from CFA logger
- attest_done  in  1  single-cycle pulse; attestation finished
- per_dout  out  16  read data; 0 when not selected
- er_min_flat  out  16*NUM_ER  ER_min of channel i at bits [16i+15:16i]
- er_max_flat  out  16*NUM_ER  ER_max, same packing
- locked  out  1  lock FSM is in LOCKED
- chal_valid  out  1  all challenge words written since last clear
- log_ovf  out  1  sticky log overflow

Behaviour:
- Reset: puc_rst is asynchronous, active-high. Clock is mclk.
- Values on reset: all registers 0, FSM OPEN, per_dout 0, locked 0, chal_valid 0, log_ovf 0.
- Word map, offsets from BASE_ADDR/2:
  - 0..CHAL_WORDS-1: CHAL
  - CHAL_WORDS: CTRL (write-only, reads 0)
  - +1: STATUS
  - +2: LOGP
  - +3: LOGHW
  - +4+2i: ERMIN[i]
  - +5+2i: ERMAX[i]
- Addresses outside this window: per_dout 0, no side effects.
- Reads are combinational and same-cycle when per_en=1 and per_we=0. Writes take effect on the next mclk edge. Byte lanes are honoured per per_we bit.
- Lock FSM (transitions apply only to CTRL writes with per_we=2'b11; byte writes to CTRL are ignored):
  - OPEN: UNLOCK_KEY -> ARMED.
  - ARMED: LOCK_KEY -> LOCKED; any other value -> OPEN.
  - LOCKED: CTRL writes ignored.
  - attest_done=1 in any state -> OPEN on the next edge. It clears the challenge-written mask and chal_valid. It takes priority over a same-cycle CTRL write.
- While LOCKED, writes to CHAL or ERMIN/ERMAX are dropped and set STATUS.wr_viol.
- Challenge tracking:
  - A CHAL_WORDS-bit mask sets bit k on any accepted write to CHAL[k].
  - chal_valid = AND of the mask, registered in the same cycle as the mask.
  - Rewriting a word keeps its bit set.
- STATUS bits:
  - [1:0] FSM state: 0 OPEN, 1 ARMED, 2 LOCKED
  - [2] chal_valid
  - [3] wr_viol (sticky)
  - [4] log_ovf (sticky)
  - [15:5] 0
- STATUS[4:3] are write-1-to-clear and may be cleared in any state. If a set and a clear occur in the same cycle, the set wins.
- Log tracking:
  - LOGP <= cflow_logs_ptr_din every cycle (one-cycle lag). It is read-only; writes are ignored.
  - LOGHW <= LOGP when LOGP > LOGHW (unsigned). Writing LOGHW while OPEN resets it to per_din; writing it while LOCKED is dropped and sets wr_viol.
  - log_ovf sets when LOGP >= LOG_LIMIT.
- er_min_flat and er_max_flat mirror the registers directly with no extra latency beyond the write edge.
- Reset mid-sequence (e.g. in ARMED) returns the FSM to OPEN and clears everything.

Test Plan:
- Write ERMIN[1]=16'h4000 and ERMAX[1]=16'h4FFE while OPEN, then read back -> reads 4000/4FFE; er_min_flat[31:16]=16'h4000; wr_viol=0.
- CTRL A5A5 then 5A5A -> STATUS[1:0]=2, locked=1. Then write ERMIN[0]=16'h1234 -> ERMIN[0] unchanged, STATUS[3]=1. Write STATUS=16'h0008 -> STATUS[3]=0.
- CTRL A5A5 then 1111 -> FSM returns to OPEN (STATUS[1:0]=0). A byte write of A5A5 with per_we=01 causes no transition.
- Write CHAL[0..14] -> chal_valid=0. Write CHAL[15] -> chal_valid=1 after that edge. Pulse attest_done -> chal_valid=0, locked=0.
- Drive cflow_logs_ptr_din 0x0100, then 0x0300, then 0x0200 -> LOGHW=0x0300. Drive 0x0400 -> log_ovf=1 two cycles after the input changes (input registered into LOGP, then flag set). A W1C issued in the same cycle the overflow condition holds leaves log_ovf=1.
- Assert puc_rst while in ARMED with wr_viol set -> all outputs 0 and FSM OPEN asynchronously. Read of an unmapped address BASE+0x40 -> per_dout=0.

Source files
------------

// File: rtl/acfa_metadata_regs.sv
// ACFA metadata peripheral: attestation challenge, executable-region bounds,
// control-flow log pointer tracking and a two-step lock that freezes them.
module acfa_metadata_regs #(
   parameter logic [14:0] BASE_ADDR  = 15'h0180,
   parameter int unsigned CHAL_WORDS = 16,
   parameter int unsigned NUM_ER     = 2,
   parameter logic [15:0] LOG_LIMIT  = 16'h0400,
   parameter logic [15:0] UNLOCK_KEY = 16'hA5A5,
   parameter logic [15:0] LOCK_KEY   = 16'h5A5A
) (
   input  logic                  mclk,
   input  logic                  puc_rst,
   input  logic [13:0]           per_addr,
   input  logic [15:0]           per_din,
   input  logic                  per_en,
   input  logic [1:0]            per_we,
   input  logic [15:0]           cflow_logs_ptr_din,
   input  logic                  attest_done,
   output logic [15:0]           per_dout,
   output logic [16*NUM_ER-1:0]  er_min_flat,
   output logic [16*NUM_ER-1:0]  er_max_flat,
   output logic                  locked,
   output logic                  chal_valid,
   output logic                  log_ovf
);

   typedef enum logic [1:0] {ST_OPEN = 2'd0, ST_ARMED = 2'd1, ST_LOCKED = 2'd2} state_t;

   localparam int unsigned WIN    = CHAL_WORDS + 4 + 2*NUM_ER;
   localparam logic [13:0] BASE_W = BASE_ADDR[14:1];
   localparam logic [13:0] CTRL_O = 14'(CHAL_WORDS);
   localparam logic [13:0] STAT_O = 14'(CHAL_WORDS + 1);
   localparam logic [13:0] LOGP_O = 14'(CHAL_WORDS + 2);
   localparam logic [13:0] LGHW_O = 14'(CHAL_WORDS + 3);
   localparam logic [13:0] ER_O   = 14'(CHAL_WORDS + 4);

   state_t                         state;
   logic [CHAL_WORDS-1:0][15:0]    chal;
   logic [NUM_ER-1:0][15:0]        er_min, er_max;
   logic [CHAL_WORDS-1:0]          chal_mask, chal_mask_nxt, chal_wr;
   logic [NUM_ER-1:0]              ermin_wr, ermax_wr;
   logic [15:0]                    logp, loghw, status;
   logic [13:0]                    off;
   logic                           hit, rd, wr, is_locked;
   logic                           ctrl_wr, stat_wr, loghw_wr, viol_set, ovf_set, wr_viol;

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                         input logic [1:0] we);
      merge = {we[1] ? din[15:8] : old[15:8], we[0] ? din[7:0] : old[7:0]};
   endfunction

   assign off       = per_addr - BASE_W;
   assign hit       = (per_addr >= BASE_W) && (off < 14'(WIN));
   assign rd        = per_en && (per_we == 2'b00) && hit;
   assign wr        = per_en && (per_we != 2'b00) && hit;
   assign is_locked = (state == ST_LOCKED);
   assign locked    = is_locked;
   assign ctrl_wr   = wr && (off == CTRL_O);
   assign stat_wr   = wr && (off == STAT_O);
   assign loghw_wr  = wr && (off == LGHW_O);
   assign viol_set  = wr && is_locked && ((off < CTRL_O) || (off == LGHW_O) || (off >= ER_O));
   assign ovf_set   = (logp >= LOG_LIMIT);
   assign status    = {11'd0, log_ovf, wr_viol, chal_valid, state};

   assign er_min_flat = er_min;
   assign er_max_flat = er_max;

   always_comb begin
      chal_wr  = '0;
      ermin_wr = '0;
      ermax_wr = '0;
      for (int k = 0; k < CHAL_WORDS; k++)
         chal_wr[k] = wr && (off == 14'(k));
      for (int i = 0; i < NUM_ER; i++) begin
         ermin_wr[i] = wr && (off == ER_O + 14'(2*i));
         ermax_wr[i] = wr && (off == ER_O + 14'(2*i + 1));
      end
      // attestation end wins over any same-cycle challenge write
      if (attest_done)
         chal_mask_nxt = '0;
      else
         chal_mask_nxt = chal_mask | (is_locked ? '0 : chal_wr);
   end

   always_comb begin
      per_dout = '0;
      if (rd) begin
         for (int k = 0; k < CHAL_WORDS; k++)
            if (off == 14'(k)) per_dout = chal[k];
         if (off == STAT_O) per_dout = status;
         if (off == LOGP_O) per_dout = logp;
         if (off == LGHW_O) per_dout = loghw;
         for (int i = 0; i < NUM_ER; i++) begin
            if (off == ER_O + 14'(2*i))     per_dout = er_min[i];
            if (off == ER_O + 14'(2*i + 1)) per_dout = er_max[i];
         end
      end
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         state <= ST_OPEN;
      end else if (attest_done) begin
         state <= ST_OPEN;
      end else if (ctrl_wr && per_we == 2'b11) begin
         case (state)
            ST_OPEN:  if (per_din == UNLOCK_KEY) state <= ST_ARMED;
            ST_ARMED: state <= (per_din == LOCK_KEY) ? ST_LOCKED : ST_OPEN;
            default:  state <= state;
         endcase
      end
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         chal       <= '0;
         er_min     <= '0;
         er_max     <= '0;
         chal_mask  <= '0;
         chal_valid <= 1'b0;
      end else begin
         chal_mask  <= chal_mask_nxt;
         chal_valid <= &chal_mask_nxt;
         if (!is_locked) begin
            for (int k = 0; k < CHAL_WORDS; k++)
               if (chal_wr[k]) chal[k] <= merge(chal[k], per_din, per_we);
            for (int i = 0; i < NUM_ER; i++) begin
               if (ermin_wr[i]) er_min[i] <= merge(er_min[i], per_din, per_we);
               if (ermax_wr[i]) er_max[i] <= merge(er_max[i], per_din, per_we);
            end
         end
      end
   end

   // sticky flags: a set in the same cycle as a write-1-to-clear wins
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         logp    <= '0;
         loghw   <= '0;
         wr_viol <= 1'b0;
         log_ovf <= 1'b0;
      end else begin
         logp    <= cflow_logs_ptr_din;
         wr_viol <= viol_set | (wr_viol & ~(stat_wr & per_we[0] & per_din[3]));
         log_ovf <= ovf_set  | (log_ovf & ~(stat_wr & per_we[0] & per_din[4]));
         if (loghw_wr && !is_locked)
            loghw <= merge(loghw, per_din, per_we);
         else if (logp > loghw)
            loghw <= logp;
      end
   end

endmodule

// File: tb/tb_acfa_metadata_regs.sv
// Directed bench for acfa_metadata_regs; expectations queue up as stimulus is
// driven and are popped when the matching DUT value is sampled.
module tb_acfa_metadata_regs;

   localparam logic [13:0] CHAL0 = 14'h00C0;
   localparam logic [13:0] CTRL  = 14'h00D0;
   localparam logic [13:0] STAT  = 14'h00D1;
   localparam logic [13:0] LOGP  = 14'h00D2;
   localparam logic [13:0] LOGHW = 14'h00D3;
   localparam logic [13:0] ERMN0 = 14'h00D4;
   localparam logic [13:0] ERMN1 = 14'h00D6;
   localparam logic [13:0] ERMX1 = 14'h00D7;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] cflow_logs_ptr_din;
   logic        attest_done;
   logic [15:0] per_dout;
   logic [31:0] er_min_flat, er_max_flat;
   logic        locked, chal_valid, log_ovf;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   acfa_metadata_regs dut (
      .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
      .per_en(per_en), .per_we(per_we), .cflow_logs_ptr_din(cflow_logs_ptr_din),
      .attest_done(attest_done), .per_dout(per_dout), .er_min_flat(er_min_flat),
      .er_max_flat(er_max_flat), .locked(locked), .chal_valid(chal_valid),
      .log_ovf(log_ovf)
   );

   always #5 mclk = ~mclk;

   task automatic push_exp(input logic [31:0] e);
      sb.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic ochk(input string tag, input logic [31:0] obs, input logic [31:0] e);
      push_exp(e);
      chk(tag, obs);
   endtask

   task automatic rd(input logic [13:0] a, input logic [15:0] e, input string tag);
      push_exp({16'd0, e});
      per_en = 1'b1; per_we = 2'b00; per_addr = a;
      #1;
      chk(tag, {16'd0, per_dout});
      per_en = 1'b0;
   endtask

   task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
      @(posedge mclk); #1;
      per_en = 1'b1; per_we = we; per_addr = a; per_din = d;
      @(posedge mclk); #1;
      per_en = 1'b0; per_we = 2'b00;
   endtask

   task automatic pulse_attest();
      @(posedge mclk); #1;
      attest_done = 1'b1;
      @(posedge mclk); #1;
      attest_done = 1'b0;
   endtask

   task automatic set_ptr(input logic [15:0] p);
      @(posedge mclk); #1;
      cflow_logs_ptr_din = p;
      repeat (2) @(posedge mclk);
      #1;
   endtask

   initial begin
      puc_rst = 1'b1; per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
      cflow_logs_ptr_din = '0; attest_done = 1'b0;
      #12;
      rd(STAT, 16'h0000, "rst_status");
      ochk("rst_locked", {31'd0, locked}, 0);
      ochk("rst_chal_valid", {31'd0, chal_valid}, 0);
      ochk("rst_log_ovf", {31'd0, log_ovf}, 0);
      ochk("rst_er_min", er_min_flat, 0);
      @(negedge mclk); puc_rst = 1'b0;

      // ER programming while open
      wr(ERMN1, 16'h4000, 2'b11);
      wr(ERMX1, 16'h4FFE, 2'b11);
      rd(ERMN1, 16'h4000, "ermin1_rb");
      rd(ERMX1, 16'h4FFE, "ermax1_rb");
      ochk("er_min_flat_hi", {16'd0, er_min_flat[31:16]}, 32'h4000);
      ochk("er_max_flat_hi", {16'd0, er_max_flat[31:16]}, 32'h4FFE);
      rd(STAT, 16'h0000, "status_open_noviol");
      wr(ERMN1, 16'h00AB, 2'b01);
      rd(ERMN1, 16'h40AB, "ermin1_byte_lo");

      // lock, violation, W1C
      wr(CTRL, 16'hA5A5, 2'b11);
      rd(STAT, 16'h0001, "status_armed");
      wr(CTRL, 16'h5A5A, 2'b11);
      rd(STAT, 16'h0002, "status_locked");
      ochk("locked_out", {31'd0, locked}, 1);
      rd(CTRL, 16'h0000, "ctrl_reads_zero");
      wr(ERMN0, 16'h1234, 2'b11);
      rd(ERMN0, 16'h0000, "ermin0_dropped");
      rd(STAT, 16'h000A, "status_viol");
      wr(STAT, 16'h0008, 2'b11);
      rd(STAT, 16'h0002, "status_w1c_viol");
      pulse_attest();
      rd(STAT, 16'h0000, "status_after_attest");
      ochk("unlocked_out", {31'd0, locked}, 0);

      // abort sequence and byte writes to CTRL
      wr(CTRL, 16'hA5A5, 2'b11);
      wr(CTRL, 16'h1111, 2'b11);
      rd(STAT, 16'h0000, "abort_to_open");
      wr(CTRL, 16'hA5A5, 2'b01);
      rd(STAT, 16'h0000, "byte_ctrl_ignored");

      // challenge tracking
      for (int k = 0; k < 15; k++) wr(CHAL0 + 14'(k), 16'(k * 16'h0111), 2'b11);
      ochk("chal_valid_15", {31'd0, chal_valid}, 0);
      rd(CHAL0 + 14'd3, 16'h0333, "chal3_rb");
      wr(CHAL0 + 14'd3, 16'hBEEF, 2'b11);
      ochk("chal_valid_rewrite", {31'd0, chal_valid}, 0);
      wr(CHAL0 + 14'd15, 16'hCAFE, 2'b11);
      ochk("chal_valid_16", {31'd0, chal_valid}, 1);
      rd(STAT, 16'h0004, "status_chal_valid");
      wr(CTRL, 16'hA5A5, 2'b11);
      wr(CTRL, 16'h5A5A, 2'b11);
      rd(STAT, 16'h0006, "status_locked_valid");
      pulse_attest();
      ochk("attest_clr_valid", {31'd0, chal_valid}, 0);
      ochk("attest_clr_locked", {31'd0, locked}, 0);

      // log pointer tracking
      set_ptr(16'h0100);
      set_ptr(16'h0300);
      set_ptr(16'h0200);
      rd(LOGHW, 16'h0300, "loghw_peak");
      rd(LOGP, 16'h0200, "logp_follow");
      wr(LOGP, 16'hFFFF, 2'b11);
      rd(LOGP, 16'h0200, "logp_readonly");
      @(posedge mclk); #1;
      cflow_logs_ptr_din = 16'h0400;
      @(posedge mclk); #1;
      ochk("ovf_lag1", {31'd0, log_ovf}, 0);
      @(posedge mclk); #1;
      ochk("ovf_lag2", {31'd0, log_ovf}, 1);
      wr(STAT, 16'h0010, 2'b11);
      ochk("ovf_set_wins", {31'd0, log_ovf}, 1);
      rd(STAT, 16'h0010, "status_ovf");
      set_ptr(16'h0000);
      wr(STAT, 16'h0010, 2'b11);
      ochk("ovf_cleared", {31'd0, log_ovf}, 0);
      wr(LOGHW, 16'h0050, 2'b11);
      rd(LOGHW, 16'h0050, "loghw_write_open");

      // reset from ARMED with wr_viol and log_ovf set
      wr(CTRL, 16'hA5A5, 2'b11);
      wr(CTRL, 16'h5A5A, 2'b11);
      wr(LOGHW, 16'h0007, 2'b11);
      rd(LOGHW, 16'h0050, "loghw_locked_drop");
      pulse_attest();
      wr(CTRL, 16'hA5A5, 2'b11);
      set_ptr(16'h0400);
      @(posedge mclk); #1;
      rd(STAT, 16'h0019, "status_pre_reset");
      #2;
      puc_rst = 1'b1;
      cflow_logs_ptr_din = 16'h0000;
      #1;
      rd(STAT, 16'h0000, "status_async_rst");
      ochk("rst2_log_ovf", {31'd0, log_ovf}, 0);
      ochk("rst2_er_max", er_max_flat, 0);
      ochk("rst2_locked", {31'd0, locked}, 0);
      @(negedge mclk); puc_rst = 1'b0;
      rd(ERMN1, 16'h0000, "ermin1_after_rst");
      rd(CHAL0 + 14'h20, 16'h0000, "unmapped_read");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
